// File: rtl/fifo_burst_reader.sv
// Drains a show-ahead FIFO in BURST_LEN-word bursts onto a registered valid/ready stream.
// Define FIFO_BURST_READER_TIMEOUT_EN to flush partial bursts after TIMEOUT idle cycles.
module fifo_burst_reader #(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 4,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic [AWIDTH:0]   fifo_usedw_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rdreq_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o,
  output logic              busy_o
);

  // Stream handshake: a word transfers on a rising clk_i where valid_o && ready_i.
  // While valid_o && !ready_i, data_o/last_o/valid_o are held stable.

  localparam int RCW = $clog2(BURST_LEN + 1);
  localparam logic [RCW-1:0] LAST_IDX    = RCW'(BURST_LEN - 1);
  localparam logic [AWIDTH:0] BURST_LEN_W = (AWIDTH + 1)'(BURST_LEN);

  if (BURST_LEN < 1 || BURST_LEN > (1 << AWIDTH)) begin : g_bad_burst_len
    $error("fifo_burst_reader: BURST_LEN must be in 1..2**AWIDTH");
  end

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [TCW-1:0]  TO_MAX     = TCW'(TIMEOUT - 1);
  localparam logic [AWIDTH:0] USEDW_ONE  = (AWIDTH + 1)'(1);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fifo_burst_reader: TIMEOUT must be >= 1");
  end
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    ST_FLUSH = 2'd2,
`endif
    ST_BURST = 2'd1
  } state_t;

  state_t         state_q, state_d;
  logic [RCW-1:0] rd_cnt_q;
  logic           load;
  logic           rdreq;
  logic           pop_last;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  logic [TCW-1:0] to_cnt_q;
`endif

  assign load = !valid_o || ready_i;

  always_comb begin
    state_d  = state_q;
    rdreq    = 1'b0;
    pop_last = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_usedw_i >= BURST_LEN_W) begin
          state_d = ST_BURST;
        end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        else if (to_cnt_q == TO_MAX && !fifo_empty_i) begin
          state_d = ST_FLUSH;
        end
`endif
      end
      ST_BURST: begin
        rdreq    = !fifo_empty_i && load;
        pop_last = rdreq && (rd_cnt_q == LAST_IDX);
        if (pop_last) state_d = ST_IDLE;
      end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
      // A flush ends on the last queued word, but never runs past BURST_LEN words
      // even if the writer keeps adding data.
      ST_FLUSH: begin
        rdreq    = !fifo_empty_i && load;
        pop_last = rdreq && ((fifo_usedw_i == USEDW_ONE) || (rd_cnt_q == LAST_IDX));
        if (pop_last) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign fifo_rdreq_o = rdreq;
  assign busy_o       = (state_q != ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt_q <= '0;
    end else if (rdreq) begin
      rd_cnt_q <= pop_last ? '0 : rd_cnt_q + RCW'(1);
    end
  end

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  // Counts consecutive idle cycles with data waiting; saturates at TO_MAX.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_q <= '0;
    end else if (state_q != ST_IDLE || state_d != ST_IDLE || fifo_empty_i) begin
      to_cnt_q <= '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_q <= to_cnt_q + TCW'(1);
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else if (rdreq) begin
      data_o  <= fifo_q_i;
      valid_o <= 1'b1;
      last_o  <= pop_last;
    end else if (load) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural show-ahead FIFO, directed bursts, stall,
// timeout/no-timeout, back-to-back, mid-burst reset and a random ordering run.
module tb_fifo_burst_reader;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int BL    = 4;
  localparam int TO    = 16;
  localparam int DEPTH = 16;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
  localparam bit CHK_LAST = 1'b0;
`else
  localparam bit CHK_LAST = 1'b1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] fifo_q;
  logic [AW:0]   fifo_usedw;
  logic          fifo_empty;
  logic          fifo_rdreq;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready = 1'b1;
  logic          last_o;
  logic          busy_o;

  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          fifo_clr = 1'b1;

  // clock / reset
  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DWIDTH(DW), .AWIDTH(AW), .BURST_LEN(BL), .TIMEOUT(TO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .fifo_q_i     (fifo_q),
    .fifo_usedw_i (fifo_usedw),
    .fifo_empty_i (fifo_empty),
    .fifo_rdreq_o (fifo_rdreq),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready),
    .last_o       (last_o),
    .busy_o       (busy_o)
  );

  // show-ahead FIFO model
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          pop_m;

  assign pop_m      = fifo_rdreq && (cnt != 0);
  assign fifo_q     = mem[rp];
  assign fifo_empty = (cnt == 0);
  assign fifo_usedw = cnt;

  always @(posedge clk) begin
    if (fifo_clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp      <= wp + 1'b1;
      end
      if (pop_m) rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop_m};
    end
  end

  // scoreboard
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] mon_item;
  int n_vec = 0;
  int n_err = 0;
  int last_seen = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_rdreq) check("rdreq_while_empty", 32'(fifo_empty), 32'd0);
      if (valid_o && ready) begin
        if (last_o) last_seen++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL stream_extra: got data %0h, required no word", data_o);
        end else begin
          mon_item = exp_q.pop_front();
          check("stream_data", 32'(data_o), 32'(mon_item[DW-1:0]));
          if (mon_item[DW+1]) check("stream_last", 32'(last_o), 32'(mon_item[DW]));
        end
      end
    end
  end

  // driver tasks (called at posedge+1)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic l, input logic chk);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back({chk, l, d});
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_o) begin
        found = 1'b1;
        break;
      end
    end
    check(name, 32'(found), 32'd1);
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && cnt == 0 && !valid_o) begin
        done = 1'b1;
        break;
      end
    end
    check(name, 32'(done), 32'd1);
    tick();
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
  endtask

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout, required completion");
    summary();
    $fatal(1);
  end

  initial begin
    int total, run, maxrun, n_rnd;
    logic [19:0] got_pat, exp_pat;
    logic [DW-1:0] d;
    int last_base;

    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_last",  32'(last_o), 32'd0);
    check("reset_busy",  32'(busy_o), 32'd0);
    check("reset_rdreq", 32'(fifo_rdreq), 32'd0);
    check("reset_data",  32'(data_o), 32'd0);
    fifo_clr = 1'b0;
    rst_n    = 1'b1;
    tick();

    // single full burst, ready held high
    for (int i = 0; i < 4; i++) begin
      d = 8'(8'h11 * (i + 1));
      push_word(d, i == 3, 1'b1);
    end
    total = 0; run = 0; maxrun = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (fifo_rdreq) begin
        total++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    check("t1_rdreq_total", 32'(total), 32'd4);
    check("t1_rdreq_run", 32'(maxrun), 32'd4);
    tick();
    wait_drain("t1_drain");
    check("t1_busy_after", 32'(busy_o), 32'd0);

    // stall on the first word
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = 8'(8'h11 * (i + 1));
      push_word(d, i == 3, 1'b1);
    end
    wait_valid("t2_first_valid");
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      check("t2_hold_data", 32'(data_o), 32'h11);
      check("t2_hold_valid", 32'(valid_o), 32'd1);
      check("t2_hold_rdreq", 32'(fifo_rdreq), 32'd0);
    end
    tick();
    ready = 1'b1;
    wait_drain("t2_drain");

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    // partial burst flushed by timeout
    push_word(8'hA1, 1'b0, 1'b1);
    push_word(8'hA2, 1'b1, 1'b1);
    total = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_rdreq) total++;
    end
    check("t3_no_early_flush", 32'(total), 32'd0);
    tick();
    wait_drain("t3_flush_drain");
    check("t3_fifo_empty", 32'(fifo_empty), 32'd1);
`else
    // partial data stays until a full burst is available
    push_word(8'hB1, 1'b0, 1'b1);
    push_word(8'hB2, 1'b0, 1'b1);
    total = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_rdreq) total++;
    end
    check("t3_no_partial_read", 32'(total), 32'd0);
    check("t3_usedw_held", 32'(fifo_usedw), 32'd2);
    tick();
    push_word(8'hB3, 1'b0, 1'b1);
    push_word(8'hB4, 1'b1, 1'b1);
    wait_drain("t3_burst_drain");
`endif

    // fill to 16 while held in reset, then four back-to-back bursts
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d = 8'(8'h40 + i);
      push_word(d, (i % 4) == 3, 1'b1);
    end
    check("t4_full", 32'(fifo_usedw), 32'd16);
    last_base = last_seen;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      got_pat[k] = fifo_rdreq;
      exp_pat[k] = (k % 5) != 0;
    end
    check("t4_rdreq_pattern", 32'(got_pat), 32'(exp_pat));
    tick();
    wait_drain("t4_drain");
    check("t4_last_pulses", 32'(last_seen - last_base), 32'd4);
    check("t4_fifo_empty", 32'(fifo_empty), 32'd1);
    check("t4_busy_after", 32'(busy_o), 32'd0);

    // asynchronous reset during word 2 of a burst
    for (int i = 0; i < 4; i++) begin
      d = 8'(8'hC1 + i);
      push_word(d, i == 3, 1'b1);
    end
    wait_valid("t5_first_valid");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(valid_o), 32'd0);
    check("t5_async_last",  32'(last_o), 32'd0);
    check("t5_async_busy",  32'(busy_o), 32'd0);
    check("t5_async_rdreq", 32'(fifo_rdreq), 32'd0);
    exp_q.delete();
    tick();
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
    rst_n    = 1'b1;
    tick();
    tick();
    check("t5_idle_busy",  32'(busy_o), 32'd0);
    check("t5_idle_valid", 32'(valid_o), 32'd0);

    // random ordering run
    n_rnd = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      ready = 1'($urandom_range(0, 1));
      if (cnt < 5'(DEPTH) && $urandom_range(0, 1) == 1) begin
        d       = 8'($urandom_range(0, 255));
        wr_en   = 1'b1;
        wr_data = d;
        exp_q.push_back({CHK_LAST, (n_rnd % BL) == BL - 1, d});
        n_rnd++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    ready = 1'b1;
    while ((n_rnd % BL) != 0) begin
      d = 8'($urandom_range(0, 255));
      push_word(d, (n_rnd % BL) == BL - 1, CHK_LAST);
      n_rnd++;
    end
    wait_drain("t6_random_drain");
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    summary();
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side master for the team's show-ahead `fifo` (`q_o` is valid whenever `empty_o` = 0; `rdreq_i` pops).
- Drains the FIFO in fixed-length bursts onto a registered valid/ready stream, and marks the final word of each burst with `last_o`.
- Sits between a `fifo` instance and a downstream packet consumer.
- Optional timeout path flushes partial bursts.

Parameters:
- `DWIDTH`, 8: data width; must match the FIFO.
- `AWIDTH`, 4: FIFO address width; usedw is `AWIDTH+1` bits.
- `BURST_LEN`, 4: words per full burst; legal range 1..2**AWIDTH (elaboration `$error` otherwise).
- `TIMEOUT`, 16: idle cycles with a non-empty FIFO before a partial flush; must be >= 1.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `fifo_q_i`  in  `DWIDTH`  FIFO show-ahead data
- `fifo_usedw_i`  in  `AWIDTH+1`  FIFO fill level
- `fifo_empty_i`  in  1  FIFO empty flag
- `fifo_rdreq_o`  out  1  FIFO pop request
- `data_o`  out  `DWIDTH`  stream data (registered)
- `valid_o`  out  1  stream valid
- `ready_i`  in  1  stream ready
- `last_o`  out  1  final word of burst
- `busy_o`  out  1  state != IDLE

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Asserting `rst_ni` low immediately forces: state IDLE, `valid_o` 0, `data_o` 0, `last_o` 0, read counter 0, timeout counter 0, `busy_o` 0, `fifo_rdreq_o` 0.
  - Reset mid-burst abandons the burst. Words already popped are lost. No `last_o` is emitted.
- Output slot: `load = !valid_o || ready_i`.
- Read request (combinational): `fifo_rdreq_o = (state in {BURST, FLUSH}) && !fifo_empty_i && load`. The block never pops an empty FIFO.
- Read cycle: on a clock where `fifo_rdreq_o` = 1:
  - `data_o` <= `fifo_q_i` and `valid_o` <= 1.
  - `last_o` <= 1 if this is word `BURST_LEN` in BURST, or if `fifo_usedw_i == 1` in FLUSH; otherwise 0.
  - Read counter increments.
- No read with `load`: `valid_o` <= 0 and `last_o` <= 0.
- Otherwise `data_o`, `valid_o` and `last_o` hold. The stream is stable while `valid_o && !ready_i`.
- Latency: FIFO word to `data_o` is 1 cycle. Throughput is 1 word/cycle while `ready_i` = 1.
- FSM:
  - IDLE -> BURST when `fifo_usedw_i >= BURST_LEN`. This has priority over timeout.
  - IDLE -> FLUSH when the timeout counter equals `TIMEOUT-1` and `!fifo_empty_i`.
  - IDLE: the timeout counter increments each cycle while `!fifo_empty_i`. It clears when the FIFO is empty or on leaving IDLE.
  - BURST -> IDLE on the clock that pops word `BURST_LEN`; the read counter clears. The FIFO cannot become empty mid-burst, because the level is >= `BURST_LEN` at entry and only this block reads.
  - FLUSH -> IDLE on the clock that pops a word with `fifo_usedw_i == 1`, or that pops word `BURST_LEN`, whichever is first. Concurrent FIFO writes during FLUSH do not extend the burst beyond `BURST_LEN`.
  - Back-to-back: the next burst may start the cycle after returning to IDLE, so there is one bubble cycle between bursts.
- Counters: the read counter is `$clog2(BURST_LEN+1)` bits. The timeout counter is `$clog2(TIMEOUT+1)` bits and saturates at `TIMEOUT-1`.
- `BURST_LEN` = 1: every word is a full burst with `last_o` = 1.

Optional Feature:
- Macro: `FIFO_BURST_READER_TIMEOUT_EN`.
- Defined: FLUSH state and timeout counter are present, as described above.
- Undefined:
  - FLUSH state and timeout counter are removed.
  - Data below `BURST_LEN` stays in the FIFO indefinitely.
  - `last_o` is only ever set on word `BURST_LEN`.
  - The `TIMEOUT` parameter is ignored.

Test Plan:
- Write 4 words `0x11`,`0x22`,`0x33`,`0x44` into an empty FIFO, `ready_i` = 1, `BURST_LEN` = 4 -> `fifo_rdreq_o` high 4 consecutive cycles; `data_o` `0x11`..`0x44` with `valid_o` = 1 on the 4 cycles after; `last_o` only with `0x44`; `busy_o` low afterwards.
- Same stimulus, `ready_i` = 0 for 3 cycles after the first word -> `data_o` holds `0x11` with `valid_o` = 1 and `fifo_rdreq_o` = 0 during the stall; the sequence resumes without loss or duplication.
- (`TIMEOUT_EN`) write 2 words, no further writes -> after 16 cycles FLUSH starts; 2 words are output with `last_o` on the 2nd; the FIFO ends empty; `fifo_rdreq_o` never asserts while `fifo_empty_i` = 1.
- (no macro) write 2 words, wait 100 cycles -> `fifo_rdreq_o` stays 0 and `fifo_usedw_i` stays 2; writing 2 more triggers a 4-word burst.
- Fill to 16 words with `BURST_LEN` = 4 -> 4 bursts separated by one bubble cycle each; 4 `last_o` pulses; the FIFO ends empty.
- Pull `rst_ni` low during word 2 of a burst -> `valid_o`, `last_o`, `busy_o` and `fifo_rdreq_o` drop to 0 before the next clock edge; after release the state is IDLE.
- Random: a scoreboard compares `data_o` order against the write order over 10000 cycles with 50% random `ready_i`.
